// File: rtl/dmem_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the M stage.
// Loads hit in zero cycles; misses and all stores stall until the memory acks.
module dmem_cache #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [31:0] addrM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hitcnt,
  output logic [31:0] misscnt,
  output logic [1:0]  dbg_state
);

  localparam int IB = $clog2(LINES);
  localparam int TW = 30 - IB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LINES-1:0] r_valid;
  logic [TW-1:0]    r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  logic [IB-1:0] w_index;
  logic [TW-1:0] w_tag;
  logic [IB-1:0] w_fill_index;
  logic [TW-1:0] w_fill_tag;
  logic          w_hit;

  assign w_index      = addrM[IB+1:2];
  assign w_tag        = addrM[31:IB+2];
  assign w_fill_index = mem_addr[IB+1:2];
  assign w_fill_tag   = mem_addr[31:IB+2];
  assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign dbg_state    = r_state;

  // Store wins when both request bits are set.
  always_comb begin
    w_next    = r_state;
    stallM    = 1'b0;
    readdataM = r_data[w_index];
    case (r_state)
      IDLE: begin
        if (memwriteM) begin
          stallM = 1'b1;
          w_next = WRITE;
        end else if (memreadM && !w_hit) begin
          stallM = 1'b1;
          w_next = FILL;
        end
      end
      FILL: begin
        if (mem_ack) begin
          readdataM = mem_rdata;
          w_next    = IDLE;
        end else begin
          stallM = 1'b1;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          w_next = IDLE;
        end else begin
          stallM = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_valid   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hitcnt    <= '0;
      misscnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (memwriteM) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {addrM[31:2], 2'b00};
            mem_wdata <= writedataM;
          end else if (memreadM) begin
            if (w_hit) begin
              hitcnt <= hitcnt + 32'd1;
            end else begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {addrM[31:2], 2'b00};
              misscnt  <= misscnt + 32'd1;
            end
          end
        end
        FILL: begin
          if (mem_ack) begin
            r_valid[w_fill_index] <= 1'b1;
            mem_req               <= 1'b0;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (r_state == IDLE && memwriteM && w_hit) begin
        r_data[w_index] <= writedataM;
      end else if (r_state == FILL && mem_ack) begin
        r_data[w_fill_index] <= mem_rdata;
        r_tag[w_fill_index]  <= w_fill_tag;
      end
    end
  end

endmodule

// File: tb/tb_dmem_cache.sv
// Directed bench for dmem_cache: a memory responder with programmable ack delay,
// driver tasks, and a monitor that checks delivered load data against exp_q.
module tb_dmem_cache;

  logic        clk;
  logic        reset;
  logic        memreadM;
  logic        memwriteM;
  logic [31:0] addrM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hitcnt;
  logic [31:0] misscnt;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  logic [31:0] mem_model [logic [31:0]];
  int          ack_delay;
  int          ack_cnt;
  int          req_count;
  int          errors;
  int          checks;

  dmem_cache #(.LINES(16)) dut (
    .clk(clk), .reset(reset),
    .memreadM(memreadM), .memwriteM(memwriteM),
    .addrM(addrM), .writedataM(writedataM),
    .readdataM(readdataM), .stallM(stallM),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hitcnt(hitcnt), .misscnt(misscnt),
    .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: holds ack low for ack_delay cycles of mem_req, then acks once
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    ack_cnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (ack_cnt == ack_delay) begin
          mem_ack = 1'b1;
          ack_cnt = 0;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
        end else begin
          ack_cnt++;
        end
      end else begin
        ack_cnt = 0;
      end
    end
  end

  always @(posedge mem_req) req_count++;

  // Monitor: each delivered load (read-only request, no stall) pops one expectation
  always @(negedge clk) begin
    if (reset && memreadM && !memwriteM && !stallM) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL load_unexpected: got %h expected no delivery", readdataM);
      end else begin
        check("load_data", readdataM, exp_q.pop_front());
      end
    end
  end

  // Drivers: entered just after a rising edge, return just after a rising edge
  task automatic do_load(input logic [31:0] a, input int dly, input logic [31:0] exp_d,
                         input int exp_stall);
    int  st;
    bit  done;
    st = 0;
    done = 0;
    ack_delay = dly;
    memreadM  = 1'b1;
    memwriteM = 1'b0;
    addrM     = a;
    exp_q.push_back(exp_d);
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (stallM) st++;
      else done = 1;
    end
    if (!done) check("load_timeout", 32'(st), 32'(exp_stall));
    else check("load_stall", 32'(st), 32'(exp_stall));
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit also_read,
                          input int dly, input int exp_stall);
    int  st;
    bit  done;
    st = 0;
    done = 0;
    ack_delay  = dly;
    memreadM   = also_read;
    memwriteM  = 1'b1;
    addrM      = a;
    writedataM = d;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("store_req", {31'b0, mem_req}, 32'd1);
        check("store_we", {31'b0, mem_we}, 32'd1);
        check("store_addr", mem_addr, {a[31:2], 2'b00});
        check("store_wdata", mem_wdata, d);
      end
      if (stallM) st++;
      else done = 1;
    end
    if (!done) check("store_timeout", 32'(st), 32'(exp_stall));
    else check("store_stall", 32'(st), 32'(exp_stall));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    memreadM  = 1'b0;
    memwriteM = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int reqs_before;
    errors     = 0;
    checks     = 0;
    req_count  = 0;
    ack_delay  = 1;
    reset      = 1'b0;
    memreadM   = 1'b0;
    memwriteM  = 1'b0;
    addrM      = '0;
    writedataM = '0;
    mem_model[32'h40]  = 32'hDEADBEEF;
    mem_model[32'h04]  = 32'h11110004;
    mem_model[32'h44]  = 32'h22220044;
    mem_model[32'h100] = 32'h0BAD0100;

    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", {31'b0, stallM}, 32'd0);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_we", {31'b0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_hitcnt", hitcnt, 32'd0);
    check("rst_misscnt", misscnt, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Cold miss then hit on the same word
    do_load(32'h40, 2, 32'hDEADBEEF, 3);
    idle_cycle();
    check("miss1_misscnt", misscnt, 32'd1);
    do_load(32'h40, 2, 32'hDEADBEEF, 0);
    idle_cycle();
    check("hit1_hitcnt", hitcnt, 32'd1);

    // Store hit updates cache and memory
    do_store(32'h40, 32'h12345678, 1'b0, 1, 2);
    idle_cycle();
    check("store_hit_mem", mem_model[32'h40], 32'h12345678);
    do_load(32'h40, 1, 32'h12345678, 0);
    idle_cycle();
    check("hit2_hitcnt", hitcnt, 32'd2);

    // Store miss does not allocate
    do_store(32'h80, 32'hCAFEF00D, 1'b0, 1, 2);
    idle_cycle();
    do_load(32'h80, 1, 32'hCAFEF00D, 2);
    idle_cycle();
    check("noalloc_misscnt", misscnt, 32'd2);

    // Index aliasing: 0x04 and 0x44 share index 1
    do_load(32'h04, 1, 32'h11110004, 2);
    idle_cycle();
    do_load(32'h44, 1, 32'h22220044, 2);
    idle_cycle();
    do_load(32'h04, 1, 32'h11110004, 2);
    idle_cycle();
    check("alias_misscnt", misscnt, 32'd5);

    // Both request bits: behaves as a store, no hit counted (0x04 now cached)
    do_store(32'h04, 32'h55AA55AA, 1'b1, 1, 2);
    idle_cycle();
    check("both_hitcnt", hitcnt, 32'd2);
    do_load(32'h04, 1, 32'h55AA55AA, 0);
    idle_cycle();
    check("both_reload_hitcnt", hitcnt, 32'd3);

    // Reset asserted in the second FILL cycle
    ack_delay = 5;
    memreadM  = 1'b1;
    addrM     = 32'h100;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("fill_state_before_rst", {30'b0, dbg_state}, 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_req", {31'b0, mem_req}, 32'd0);
    check("rst_mid_state", {30'b0, dbg_state}, 32'd0);
    memreadM = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_hitcnt", hitcnt, 32'd0);
    check("post_rst_misscnt", misscnt, 32'd0);
    do_load(32'h40, 1, 32'h12345678, 2);
    idle_cycle();
    check("post_rst_miss", misscnt, 32'd1);

    // Back-to-back loads: second hits the just-filled line, no new request
    reqs_before = req_count;
    do_load(32'h100, 1, 32'h0BAD0100, 2);
    do_load(32'h100, 1, 32'h0BAD0100, 0);
    idle_cycle();
    check("b2b_reqs", 32'(req_count - reqs_before), 32'd1);
    check("b2b_hitcnt", hitcnt, 32'd1);
    check("b2b_misscnt", misscnt, 32'd2);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
